// File: rtl/bridge_sequencer.sv
// Drawbridge sequencer: Moore FSM driving deck motors, road/boat lights and alarm.
// Define BRIDGE_WATCHDOG_EN to add the travel watchdog and the latched FAULT state.
module bridge_sequencer #(
    parameter int CLEAR_CYCLES = 16,
    parameter int HOLD_CYCLES  = 32,
    parameter int TRAVEL_MAX   = 64
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       BoatReq,
    input  logic       DeckOccupied,
    input  logic       TopLimit,
    input  logic       BottomLimit,
    input  logic       Emergency,
    output logic       MT_Up,
    output logic       MT_Down,
    output logic       AL,
    output logic       TFL,
    output logic       BGL,
    output logic [2:0] State,
    output logic       Fault
);

    typedef enum logic [2:0] {
        ST_DOWN  = 3'd0,
        ST_WARN  = 3'd1,
        ST_LIFT  = 3'd2,
        ST_UP    = 3'd3,
        ST_LOWER = 3'd4
`ifdef BRIDGE_WATCHDOG_EN
        , ST_FAULT = 3'd5
`endif
    } state_t;

    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

    generate
        if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 255) begin : g_bad_clear
            $error("CLEAR_CYCLES must be in 1..255");
        end
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("HOLD_CYCLES must be in 1..255");
        end
        if (TRAVEL_MAX < 1 || TRAVEL_MAX > 255) begin : g_bad_travel
            $error("TRAVEL_MAX must be in 1..255");
        end
    endgenerate

    state_t     state_reg, state_next;
    state_t     trip_state;
    logic [7:0] dwell_reg, dwell_next;
    logic [7:0] dwell_inc;
    logic       moving;
    logic       conflict;
    logic       frozen;
    logic       trip;
    logic       motor_en;

    assign dwell_inc = (dwell_reg == 8'hFF) ? dwell_reg : dwell_reg + 8'd1;
    assign moving    = (state_reg == ST_LIFT) || (state_reg == ST_LOWER);
    assign conflict  = moving && TopLimit && BottomLimit;
    assign motor_en  = !Emergency && !conflict;

`ifdef BRIDGE_WATCHDOG_EN
    localparam logic [7:0] TRAVEL_LIM = 8'(TRAVEL_MAX);

    logic [7:0] travel_reg, travel_next;
    logic [7:0] travel_inc;

    assign travel_inc = (travel_reg == 8'hFF) ? travel_reg : travel_reg + 8'd1;
    assign frozen     = Emergency && (state_reg != ST_FAULT);
    assign trip       = conflict || (travel_inc >= TRAVEL_LIM);
    assign trip_state = ST_FAULT;
    assign Fault      = (state_reg == ST_FAULT);
`else
    // Without the watchdog a sensor conflict simply parks the deck where it is.
    assign frozen     = Emergency;
    assign trip       = conflict;
    assign trip_state = state_reg;
    assign Fault      = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg  <= ST_DOWN;
            dwell_reg  <= '0;
`ifdef BRIDGE_WATCHDOG_EN
            travel_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            dwell_reg  <= dwell_next;
`ifdef BRIDGE_WATCHDOG_EN
            travel_reg <= travel_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        dwell_next = dwell_reg;
        if (!frozen) begin
            case (state_reg)
                ST_DOWN: begin
                    if (BoatReq && BottomLimit) state_next = ST_WARN;
                end
                ST_WARN: begin
                    if (DeckOccupied)                  dwell_next = '0;
                    else if (dwell_reg == CLEAR_LAST)  state_next = ST_LIFT;
                    else                               dwell_next = dwell_inc;
                end
                ST_LIFT: begin
                    if (trip)              state_next = trip_state;
                    else if (DeckOccupied) state_next = ST_LOWER;
                    else if (TopLimit)     state_next = ST_UP;
                end
                ST_UP: begin
                    if (BoatReq)                      dwell_next = '0;
                    else if (dwell_reg == HOLD_LAST)  state_next = ST_LOWER;
                    else                              dwell_next = dwell_inc;
                end
                ST_LOWER: begin
                    if (trip)             state_next = trip_state;
                    else if (BottomLimit) state_next = ST_DOWN;
                end
`ifdef BRIDGE_WATCHDOG_EN
                ST_FAULT: state_next = ST_FAULT;
`endif
                default: state_next = ST_DOWN;
            endcase
        end
        // Every state that uses the dwell timer starts it from zero.
        if (state_next != state_reg) dwell_next = '0;
    end

`ifdef BRIDGE_WATCHDOG_EN
    always_comb begin
        travel_next = travel_reg;
        if (state_next != state_reg &&
            (state_next == ST_LIFT || state_next == ST_LOWER)) begin
            travel_next = '0;
        end else if (!frozen && moving) begin
            travel_next = travel_inc;
        end
    end
`endif

    always_comb begin
        MT_Up   = 1'b0;
        MT_Down = 1'b0;
        AL      = 1'b0;
        TFL     = 1'b0;
        BGL     = 1'b0;
        case (state_reg)
            ST_WARN: begin
                TFL = 1'b1;
                AL  = 1'b1;
            end
            ST_LIFT: begin
                MT_Up = motor_en;
                TFL   = 1'b1;
                AL    = 1'b1;
            end
            ST_UP: begin
                TFL = 1'b1;
                BGL = 1'b1;
            end
            ST_LOWER: begin
                MT_Down = motor_en;
                TFL     = 1'b1;
                AL      = 1'b1;
            end
`ifdef BRIDGE_WATCHDOG_EN
            ST_FAULT: begin
                TFL = 1'b1;
                AL  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign State = state_reg;

endmodule

// File: tb/tb_bridge_sequencer.sv
// Bench for bridge_sequencer: cycle-level behavioural model plus directed literal checks.
// Builds with or without BRIDGE_WATCHDOG_EN; expectations follow the macro.
module tb_bridge_sequencer;

    localparam int CLEAR  = 4;
    localparam int HOLD   = 3;
    localparam int TRAVEL = 8;
`ifdef BRIDGE_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int DOWN = 0, WARN = 1, LIFT = 2, UP = 3, LOWER = 4, FLT = 5;

    // {MT_Up, MT_Down, AL, TFL, BGL, State[2:0], Fault}
    localparam logic [8:0] V_DOWN     = 9'b00000_000_0;
    localparam logic [8:0] V_WARN     = 9'b00110_001_0;
    localparam logic [8:0] V_LIFT     = 9'b10110_010_0;
    localparam logic [8:0] V_LIFT_OFF = 9'b00110_010_0;
    localparam logic [8:0] V_UP       = 9'b00011_011_0;
    localparam logic [8:0] V_LOWER    = 9'b01110_100_0;
    localparam logic [8:0] V_FAULT    = 9'b00110_101_1;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       BoatReq = 1'b0;
    logic       DeckOccupied = 1'b0;
    logic       TopLimit = 1'b0;
    logic       BottomLimit = 1'b1;
    logic       Emergency = 1'b0;
    logic       MT_Up, MT_Down, AL, TFL, BGL, Fault;
    logic [2:0] State;
    logic [8:0] dut_vec;

    int checks = 0;
    int errors = 0;

    bridge_sequencer #(
        .CLEAR_CYCLES(CLEAR),
        .HOLD_CYCLES (HOLD),
        .TRAVEL_MAX  (TRAVEL)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .BoatReq     (BoatReq),
        .DeckOccupied(DeckOccupied),
        .TopLimit    (TopLimit),
        .BottomLimit (BottomLimit),
        .Emergency   (Emergency),
        .MT_Up       (MT_Up),
        .MT_Down     (MT_Down),
        .AL          (AL),
        .TFL         (TFL),
        .BGL         (BGL),
        .State       (State),
        .Fault       (Fault)
    );

    assign dut_vec = {MT_Up, MT_Down, AL, TFL, BGL, State, Fault};

    always #5 Clock = ~Clock;

    // Model: mode plus "cycles elapsed" counts (deck-clear run, boat-quiet run, travel).
    int m_mode = DOWN;
    int m_run = 0;
    int m_quiet = 0;
    int m_travel = 0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_mode   <= DOWN;
            m_run    <= 0;
            m_quiet  <= 0;
            m_travel <= 0;
        end else if (!(Emergency && m_mode != FLT)) begin
            case (m_mode)
                DOWN: if (BoatReq && BottomLimit) begin
                    m_mode <= WARN;
                    m_run  <= 0;
                end
                WARN: begin
                    if (DeckOccupied) m_run <= 0;
                    else if (m_run + 1 == CLEAR) begin
                        m_mode   <= LIFT;
                        m_travel <= 0;
                    end else m_run <= m_run + 1;
                end
                LIFT, LOWER: begin
                    if (TopLimit && BottomLimit) begin
                        if (WD) m_mode <= FLT;
                    end else if (WD && m_travel + 1 >= TRAVEL) begin
                        m_mode <= FLT;
                    end else if (m_mode == LIFT && DeckOccupied) begin
                        m_mode   <= LOWER;
                        m_travel <= 0;
                    end else if (m_mode == LIFT && TopLimit) begin
                        m_mode  <= UP;
                        m_quiet <= 0;
                    end else if (m_mode == LOWER && BottomLimit) begin
                        m_mode <= DOWN;
                    end else begin
                        m_travel <= m_travel + 1;
                    end
                end
                UP: begin
                    if (BoatReq) m_quiet <= 0;
                    else if (m_quiet + 1 == HOLD) begin
                        m_mode   <= LOWER;
                        m_travel <= 0;
                    end else m_quiet <= m_quiet + 1;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [8:0] model_out(int mode, logic emg, logic top, logic bot);
        logic halt;
        logic up, dn, al, tfl, bgl, flt;
        halt = emg || ((mode == LIFT || mode == LOWER) && top && bot);
        up = 1'b0; dn = 1'b0; al = 1'b0; tfl = 1'b0; bgl = 1'b0; flt = 1'b0;
        case (mode)
            WARN:  begin al = 1'b1; tfl = 1'b1; end
            LIFT:  begin up = !halt; al = 1'b1; tfl = 1'b1; end
            UP:    begin tfl = 1'b1; bgl = 1'b1; end
            LOWER: begin dn = !halt; al = 1'b1; tfl = 1'b1; end
            FLT:   begin al = 1'b1; tfl = 1'b1; flt = 1'b1; end
            default: ;
        endcase
        return {up, dn, al, tfl, bgl, 3'(mode), flt};
    endfunction

    always @(posedge Clock) begin
        #1;
        checks++;
        if (dut_vec !== model_out(m_mode, Emergency, TopLimit, BottomLimit)) begin
            errors++;
            $display("FAIL model_cycle t=%0t got=%b want=%b", $time, dut_vec,
                     model_out(m_mode, Emergency, TopLimit, BottomLimit));
        end
    end

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
        end else begin
            $display("ok   %s t=%0t value=%b", name, $time, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        // Reset and nominal raise/lower cycle
        cyc(2);
        chk("reset", dut_vec, V_DOWN);
        Reset = 1'b0;
        cyc(1);
        chk("idle", dut_vec, V_DOWN);
        BoatReq = 1'b1;
        cyc(1);
        chk("warn_entry", dut_vec, V_WARN);
        BoatReq = 1'b0;
        cyc(3);
        chk("warn_dwell", State, 3'd1);
        cyc(1);
        chk("lift_entry", dut_vec, V_LIFT);
        BottomLimit = 1'b0;
        cyc(2);
        TopLimit = 1'b1;
        BoatReq  = 1'b1;
        cyc(1);
        chk("up_entry", dut_vec, V_UP);
        cyc(4);
        chk("up_boat_held", State, 3'd3);
        BoatReq = 1'b0;
        cyc(2);
        chk("up_hold", State, 3'd3);
        cyc(1);
        chk("lower_entry", dut_vec, V_LOWER);
        TopLimit = 1'b0;
        cyc(2);
        BottomLimit = 1'b1;
        cyc(1);
        chk("down_again", dut_vec, V_DOWN);

        // Deck occupied during WARN cycles 2-5, then safety reverse in LIFT
        BoatReq = 1'b1;
        cyc(1);
        chk("warn2_entry", State, 3'd1);
        cyc(1);
        DeckOccupied = 1'b1;
        cyc(4);
        chk("warn_deck_held", State, 3'd1);
        DeckOccupied = 1'b0;
        cyc(3);
        chk("warn_restart", State, 3'd1);
        cyc(1);
        chk("lift_after_deck", State, 3'd2);
        BottomLimit = 1'b0;
        BoatReq     = 1'b0;
        cyc(1);
        DeckOccupied = 1'b1;
        TopLimit     = 1'b1;
        cyc(1);
        chk("reverse", dut_vec, V_LOWER);
        DeckOccupied = 1'b0;
        TopLimit     = 1'b0;
        BottomLimit  = 1'b1;
        cyc(1);
        chk("reverse_down", dut_vec, V_DOWN);

        // Emergency in LIFT, then watchdog (or endless LIFT without it)
        BoatReq = 1'b1;
        cyc(1);
        BoatReq = 1'b0;
        cyc(4);
        chk("lift3", State, 3'd2);
        BottomLimit = 1'b0;
        cyc(2);
        Emergency = 1'b1;
        cyc(10);
        chk("emg_hold", dut_vec, V_LIFT_OFF);
        Emergency = 1'b0;
        #1;
        chk("emg_release", dut_vec, V_LIFT);
        cyc(5);
        chk("wd_excludes_emg", State, 3'd2);
        cyc(1);
        chk("wd_trip", dut_vec, WD ? V_FAULT : V_LIFT);
        cyc(5);
        chk("wd_stay", dut_vec, WD ? V_FAULT : V_LIFT);
        Reset = 1'b1;
        cyc(1);
        chk("travel_reset", dut_vec, V_DOWN);
        Reset       = 1'b0;
        BottomLimit = 1'b1;

        // Reset mid-LOWER, new request accepted afterwards
        BoatReq = 1'b1;
        cyc(1);
        BoatReq = 1'b0;
        cyc(4);
        BottomLimit  = 1'b0;
        DeckOccupied = 1'b1;
        cyc(1);
        chk("lower4", dut_vec, V_LOWER);
        DeckOccupied = 1'b0;
        cyc(1);
        Reset = 1'b1;
        cyc(1);
        chk("reset_mid_lower", dut_vec, V_DOWN);
        Reset       = 1'b0;
        BottomLimit = 1'b1;
        BoatReq     = 1'b1;
        cyc(1);
        chk("accept_after_reset", State, 3'd1);
        BoatReq = 1'b0;
        cyc(4);
        chk("lift5", State, 3'd2);

        // Sensor conflict in LIFT (both limits high)
        TopLimit = 1'b1;
        #1;
        chk("conflict_motor", dut_vec, V_LIFT_OFF);
        cyc(1);
        chk("conflict", dut_vec, WD ? V_FAULT : V_LIFT_OFF);
        cyc(2);
        TopLimit    = 1'b0;
        BottomLimit = 1'b0;
        #1;
        chk("conflict_clear", dut_vec, WD ? V_FAULT : V_LIFT);
        TopLimit = 1'b1;
        cyc(1);
        chk("after_conflict", State, WD ? 3'd5 : 3'd3);
        Reset = 1'b1;
        cyc(1);
        chk("final_reset", dut_vec, V_DOWN);
        Reset       = 1'b0;
        TopLimit    = 1'b0;
        BottomLimit = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bridge_sequencer.md
BRIDGE_SEQUENCER -- requirements
Module: bridge_sequencer

Interface
REQ-001 SHALL provide parameter CLEAR_CYCLES, default 16: WARN dwell, in cycles, before lifting; legal range 1..255.
REQ-002 SHALL provide parameter HOLD_CYCLES, default 32: minimum UP dwell, in cycles, after the last BoatReq; legal range 1..255.
REQ-003 SHALL provide parameter TRAVEL_MAX, default 64: maximum motor travel cycles, used only with WATCHDOG_EN; legal range 1..255.
REQ-004 SHALL provide port Clock, input, 1 bit: single clock; all state changes on posedge.
REQ-005 SHALL provide port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL provide port BoatReq, input, 1 bit: boat waiting or passing under the bridge.
REQ-007 SHALL provide port DeckOccupied, input, 1 bit: vehicle or pedestrian detected on the deck.
REQ-008 SHALL provide port TopLimit, input, 1 bit: deck fully raised.
REQ-009 SHALL provide port BottomLimit, input, 1 bit: deck fully lowered.
REQ-010 SHALL provide port Emergency, input, 1 bit: operator stop.
REQ-011 SHALL provide port MT_Up, output, 1 bit: raise motor drive.
REQ-012 SHALL provide port MT_Down, output, 1 bit: lower motor drive.
REQ-013 SHALL provide port AL, output, 1 bit: warning alarm.
REQ-014 SHALL provide port TFL, output, 1 bit: road traffic light red.
REQ-015 SHALL provide port BGL, output, 1 bit: boat green light.
REQ-016 SHALL provide port State, output, 3 bits: current state code.
REQ-017 SHALL provide port Fault, output, 1 bit: fault latched.

Function
REQ-018 SHALL implement states DOWN=0, WARN=1, LIFT=2, UP=3, LOWER=4, FAULT=5 in a single registered state register; State SHALL equal that register.
REQ-019 SHALL decode all outputs combinationally from the state register (Moore):
- DOWN: all outputs 0.
- WARN: TFL=1, AL=1.
- LIFT: MT_Up=1, TFL=1, AL=1.
- UP: TFL=1, BGL=1.
- LOWER: MT_Down=1, TFL=1, AL=1.
- FAULT: TFL=1, AL=1, Fault=1.
REQ-020 SHALL move DOWN->WARN on the edge where BoatReq=1 and BottomLimit=1; the dwell timer SHALL clear to 0 on entry.
REQ-021 SHALL in WARN increment the dwell timer each cycle while DeckOccupied=0 and SHALL clear it to 0 in any cycle where DeckOccupied=1.
REQ-022 SHALL move WARN->LIFT on the edge where the timer equals CLEAR_CYCLES-1 and DeckOccupied=0.
REQ-023 SHALL move LIFT->UP on the edge where TopLimit=1.
REQ-024 SHALL move LIFT->LOWER (safety reverse) on the edge where DeckOccupied=1; this takes priority over TopLimit.
REQ-025 SHALL in UP clear the dwell timer on every cycle where BoatReq=1 and otherwise increment it.
REQ-026 SHALL move UP->LOWER on the edge where BoatReq=0 and the timer equals HOLD_CYCLES-1.
REQ-027 SHALL move LOWER->DOWN on the edge where BottomLimit=1.
REQ-028 SHALL, while Emergency=1 in any state other than FAULT:
- force MT_Up=0 and MT_Down=0;
- hold the state register and all timers;
- leave the other outputs as decoded from the held state.
REQ-029 SHALL saturate all timers at 255 and never wrap.
REQ-030 SHALL treat TopLimit=1 together with BottomLimit=1 in LIFT or LOWER as a sensor conflict; conflict handling is defined in REQ-035 and REQ-036.
REQ-031 SHALL apply transition priority Reset > Emergency > conflict > watchdog > DeckOccupied reverse > normal transition.

Reset
REQ-032 SHALL, on a posedge with Reset=1, set the state to DOWN, clear all timers and clear Fault; all outputs SHALL be 0 from that edge, including when reset arrives mid-LIFT or mid-LOWER.
REQ-033 SHALL make FAULT exitable only by Reset.

Configuration
REQ-034 SHALL compile the travel watchdog in when macro BRIDGE_WATCHDOG_EN is defined.
REQ-035 SHALL, with BRIDGE_WATCHDOG_EN defined:
- count cycles spent in LIFT or LOWER, counting only while Emergency=0;
- clear the count on entry to LIFT or LOWER;
- enter FAULT when the count reaches TRAVEL_MAX;
- enter FAULT on a sensor conflict.
REQ-036 SHALL, without BRIDGE_WATCHDOG_EN:
- omit the FAULT state and the travel counter;
- tie Fault to 0;
- on a sensor conflict, hold the current state with MT_Up=0 and MT_Down=0 until the conflict clears.

Verification
REQ-037 Nominal cycle, CLEAR_CYCLES=4, HOLD_CYCLES=3: BoatReq pulse with BottomLimit=1 -> WARN for 4 cycles; then LIFT; TopLimit -> UP with BGL=1; 3 cycles after BoatReq falls -> LOWER; BottomLimit -> DOWN with all outputs 0.
REQ-038 Deck clearing: DeckOccupied=1 for cycles 2-5 of WARN -> timer restarts; LIFT entered exactly 4 cycles after DeckOccupied falls.
REQ-039 Emergency: Emergency=1 for 10 cycles in LIFT -> MT_Up=0 and State=2 held; after release, MT_Up=1 resumes; with watchdog, the count excludes those 10 cycles.
REQ-040 Safety reverse: DeckOccupied=1 in LIFT -> LOWER next edge with MT_Down=1, even when TopLimit=1 in the same cycle.
REQ-041 Watchdog, TRAVEL_MAX=8 with BRIDGE_WATCHDOG_EN: TopLimit never asserts -> FAULT after 8 LIFT cycles with Fault=1 and motors 0; Reset -> DOWN. Without the macro: the bridge stays in LIFT and Fault=0.
REQ-042 Reset mid-LOWER: Reset=1 for one edge -> State=0 and MT_Down=0 on that edge; a new BoatReq is accepted afterwards.
